// File: rtl/cu_vertex_unpack_shift_pkg.sv
// Shared types and constants for the CSR-PULL vertex unpack/shift stage.
//   - line geometry (CACHELINE_BITS, VERTEX_BITS, VERTEX_PER_LINE)
//   - array_struct_type   : which array a read response belongs to
//   - VertexInterface     : one vertex handed to the edge-request generator
//   - vertex_unpack_state : unpack FSM states
//   - swap_endianness_vertex_read : byte reversal of one 32-bit field
package cu_vertex_unpack_shift_pkg;

    localparam int CACHELINE_BITS  = 1024;
    localparam int VERTEX_BITS     = 32;
    localparam int VERTEX_PER_LINE = CACHELINE_BITS / VERTEX_BITS;
    localparam int IDX_BITS        = $clog2(VERTEX_PER_LINE);
    localparam int VERTEX_SHIFT    = $clog2(VERTEX_BITS);
    localparam int COUNT_BITS      = 6;
    localparam logic [COUNT_BITS-1:0] MAX_COUNT = COUNT_BITS'(VERTEX_PER_LINE);

    typedef enum logic [1:0] {
        INV_OUT_DEGREE = 2'd0,
        INV_EDGES_IDX  = 2'd1,
        EDGES_ARRAY    = 2'd2,
        ARRAY_NONE     = 2'd3
    } array_struct_type;

    typedef struct packed {
        logic                   valid;
        logic [VERTEX_BITS-1:0] id;
        logic [VERTEX_BITS-1:0] inverse_out_degree;
        logic [VERTEX_BITS-1:0] inverse_edges_idx;
    } VertexInterface;

    typedef enum logic [1:0] {
        UNPACK_IDLE  = 2'd0,
        UNPACK_PAIR  = 2'd1,
        UNPACK_SHIFT = 2'd2,
        UNPACK_DONE  = 2'd3
    } vertex_unpack_state;

    function automatic logic [VERTEX_BITS-1:0] swap_endianness_vertex_read(
        input logic [VERTEX_BITS-1:0] w
    );
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/cu_vertex_unpack_shift_if.sv
// Handshake bundle between the read-response side, the unpack stage and the
// edge-request generator.
//   resp_in_*        : one read-response cacheline plus its type/count/base
//   resp_in_ready    : line accepted when valid && ready
//   vertex_out       : registered vertex (valid + id/degree/idx)
//   vertex_out_ready : consumer accepts when vertex_out.valid && ready
// master = producer of lines / consumer of vertices, slave = unpack stage.
interface cu_vertex_unpack_shift_if;
    import cu_vertex_unpack_shift_pkg::*;

    logic                      resp_in_valid;
    array_struct_type          resp_in_type;
    logic [CACHELINE_BITS-1:0] resp_in_data;
    logic [COUNT_BITS-1:0]     resp_in_count;
    logic [VERTEX_BITS-1:0]    resp_in_base_id;
    logic                      resp_in_ready;
    VertexInterface            vertex_out;
    logic                      vertex_out_ready;

    modport master (
        output resp_in_valid, resp_in_type, resp_in_data, resp_in_count,
               resp_in_base_id, vertex_out_ready,
        input  resp_in_ready, vertex_out
    );

    modport slave (
        input  resp_in_valid, resp_in_type, resp_in_data, resp_in_count,
               resp_in_base_id, vertex_out_ready,
        output resp_in_ready, vertex_out
    );

endinterface

// File: rtl/cu_vertex_unpack_shift_line_slot.sv
// One buffered read-response line: data, vertex count, base id, full flag.
//   clock_i, rstn_i : clock, synchronous active-low reset (includes flush)
//   wr_i, clr_i     : capture a line / empty the slot (clear wins)
//   data_i, count_i, base_i : line to capture
//   rd_idx_i, rd_word_o     : indexed 32-bit word read
//   count_o, base_o, full_o : slot status
module cu_vertex_unpack_shift_line_slot
    import cu_vertex_unpack_shift_pkg::*;
(
    input  logic                      clock_i,
    input  logic                      rstn_i,
    input  logic                      wr_i,
    input  logic                      clr_i,
    input  logic [CACHELINE_BITS-1:0] data_i,
    input  logic [COUNT_BITS-1:0]     count_i,
    input  logic [VERTEX_BITS-1:0]    base_i,
    input  logic [IDX_BITS-1:0]       rd_idx_i,
    output logic [VERTEX_BITS-1:0]    rd_word_o,
    output logic [COUNT_BITS-1:0]     count_o,
    output logic [VERTEX_BITS-1:0]    base_o,
    output logic                      full_o
);
    logic [CACHELINE_BITS-1:0] data_q;
    logic [COUNT_BITS-1:0]     count_q;
    logic [VERTEX_BITS-1:0]    base_q;
    logic                      full_q;

    always_ff @(posedge clock_i) begin
        if (!rstn_i || clr_i) begin
            full_q  <= 1'b0;
            count_q <= '0;
            base_q  <= '0;
        end else if (wr_i) begin
            full_q  <= 1'b1;
            count_q <= count_i;
            base_q  <= base_i;
        end
    end

    // Line payload is only meaningful while full_q is set, so it carries no reset.
    always_ff @(posedge clock_i) begin
        if (wr_i) begin
            data_q <= data_i;
        end
    end

    assign rd_word_o = data_q[{rd_idx_i, {VERTEX_SHIFT{1'b0}}} +: VERTEX_BITS];
    assign count_o   = count_q;
    assign base_o    = base_q;
    assign full_o    = full_q;

endmodule

// File: rtl/cu_vertex_unpack_shift.sv
// Pairs the inverse out-degree and inverse edges-index lines of one vertex
// job, validates them, then shifts out one VertexInterface per cycle.
//   clock, rstn        : clock, synchronous active-low reset
//   enabled_in         : low flushes the block on the next edge
//   bus (slave)        : response lines in, vertices out
//   vertex_done_count  : vertices emitted since reset/flush
//   error_out          : sticky protocol error
// Build option: CU_VERTEX_ENDIAN_SWAP_EN byte-reverses degree/idx fields.
//
// state        | meaning
// UNPACK_IDLE  | both slots empty, waiting for the first line
// UNPACK_PAIR  | one slot full, waiting for the matching line
// UNPACK_SHIFT | both lines paired, emitting vertices
// UNPACK_DONE  | last vertex taken, slots cleared
module cu_vertex_unpack_shift
    import cu_vertex_unpack_shift_pkg::*;
(
    input  logic                     clock,
    input  logic                     rstn,
    input  logic                     enabled_in,
    cu_vertex_unpack_shift_if.slave  bus,
    output logic [31:0]              vertex_done_count,
    output logic                     error_out
);
    vertex_unpack_state    state_q, state_d;
    logic [COUNT_BITS-1:0] ld_idx_q, ld_idx_d;
    VertexInterface        vout_q, vout_d;
    logic [31:0]           done_cnt_q, done_cnt_d;
    logic                  err_q, err_d;

    logic                   run_n;
    logic                   deg_wr, idx_wr, clr_slots;
    logic                   deg_full, idx_full;
    logic [COUNT_BITS-1:0]  deg_count, idx_count;
    logic [VERTEX_BITS-1:0] deg_base, idx_base, deg_word, idx_word;

    logic accept, type_deg, type_idx, line_ok, other_full, pair_match, out_hs;

    function automatic logic [VERTEX_BITS-1:0] field(input logic [VERTEX_BITS-1:0] w);
`ifdef CU_VERTEX_ENDIAN_SWAP_EN
        return swap_endianness_vertex_read(w);
`else
        return w;
`endif
    endfunction

    // Reset and flush share one path.
    assign run_n = rstn && enabled_in;

    cu_vertex_unpack_shift_line_slot u_slot_deg (
        .clock_i(clock), .rstn_i(run_n), .wr_i(deg_wr), .clr_i(clr_slots),
        .data_i(bus.resp_in_data), .count_i(bus.resp_in_count),
        .base_i(bus.resp_in_base_id), .rd_idx_i(ld_idx_q[IDX_BITS-1:0]),
        .rd_word_o(deg_word), .count_o(deg_count), .base_o(deg_base),
        .full_o(deg_full)
    );

    cu_vertex_unpack_shift_line_slot u_slot_idx (
        .clock_i(clock), .rstn_i(run_n), .wr_i(idx_wr), .clr_i(clr_slots),
        .data_i(bus.resp_in_data), .count_i(bus.resp_in_count),
        .base_i(bus.resp_in_base_id), .rd_idx_i(ld_idx_q[IDX_BITS-1:0]),
        .rd_word_o(idx_word), .count_o(idx_count), .base_o(idx_base),
        .full_o(idx_full)
    );

    assign bus.resp_in_ready = run_n
                               && (state_q == UNPACK_IDLE || state_q == UNPACK_PAIR)
                               && !(deg_full && idx_full);

    assign accept     = bus.resp_in_valid && bus.resp_in_ready;
    assign type_deg   = (bus.resp_in_type == INV_OUT_DEGREE);
    assign type_idx   = (bus.resp_in_type == INV_EDGES_IDX);
    assign line_ok    = (type_deg || type_idx)
                        && (bus.resp_in_count != '0) && (bus.resp_in_count <= MAX_COUNT)
                        && !(type_deg && deg_full) && !(type_idx && idx_full);
    assign other_full = type_deg ? idx_full : deg_full;
    // Incoming line is compared against the slot it must pair with, so the
    // transition to SHIFT happens on the same edge that accepts it.
    assign pair_match = type_deg
                        ? (bus.resp_in_count == idx_count && bus.resp_in_base_id == idx_base)
                        : (bus.resp_in_count == deg_count && bus.resp_in_base_id == deg_base);
    assign out_hs     = vout_q.valid && bus.vertex_out_ready;

    always_comb begin
        state_d    = state_q;
        ld_idx_d   = ld_idx_q;
        vout_d     = vout_q;
        err_d      = err_q;
        deg_wr     = 1'b0;
        idx_wr     = 1'b0;
        clr_slots  = 1'b0;
        done_cnt_d = done_cnt_q + 32'(out_hs);

        case (state_q)
            UNPACK_IDLE, UNPACK_PAIR: begin
                if (accept) begin
                    if (!line_ok) begin
                        err_d = 1'b1;
                    end else if (other_full && !pair_match) begin
                        err_d     = 1'b1;
                        clr_slots = 1'b1;
                        state_d   = UNPACK_IDLE;
                    end else begin
                        deg_wr  = type_deg;
                        idx_wr  = type_idx;
                        state_d = other_full ? UNPACK_SHIFT : UNPACK_PAIR;
                        ld_idx_d = '0;
                    end
                end
            end
            UNPACK_SHIFT: begin
                // ld_idx_q is the next vertex to load; reaching count while the
                // output drains means the last vertex just handshook.
                if (!vout_q.valid || out_hs) begin
                    if (ld_idx_q == deg_count) begin
                        vout_d  = '0;
                        state_d = UNPACK_DONE;
                    end else begin
                        vout_d.valid              = 1'b1;
                        vout_d.id                 = deg_base + VERTEX_BITS'(ld_idx_q);
                        vout_d.inverse_out_degree = field(deg_word);
                        vout_d.inverse_edges_idx  = field(idx_word);
                        ld_idx_d                  = ld_idx_q + 1'b1;
                    end
                end
            end
            UNPACK_DONE: begin
                clr_slots = 1'b1;
                state_d   = UNPACK_IDLE;
            end
            default: state_d = UNPACK_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!run_n) begin
            state_q    <= UNPACK_IDLE;
            ld_idx_q   <= '0;
            vout_q     <= '0;
            done_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_idx_q   <= ld_idx_d;
            vout_q     <= vout_d;
            done_cnt_q <= done_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.vertex_out    = vout_q;
    assign vertex_done_count = done_cnt_q;
    assign error_out         = err_q;

endmodule

// File: tb/tb_cu_vertex_unpack_shift.sv
module tb_cu_vertex_unpack_shift;
    import cu_vertex_unpack_shift_pkg::*;

    logic        clock = 1'b0;
    logic        rstn;
    logic        enabled_in;
    logic [31:0] vertex_done_count;
    logic        error_out;

    cu_vertex_unpack_shift_if bus();

    cu_vertex_unpack_shift dut (
        .clock(clock),
        .rstn(rstn),
        .enabled_in(enabled_in),
        .bus(bus),
        .vertex_done_count(vertex_done_count),
        .error_out(error_out)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    VertexInterface            exp_q[$];
    logic                      stall_pend = 1'b0;
    VertexInterface            stall_val;
    logic [31:0]               dw [VERTEX_PER_LINE];
    logic [31:0]               iw [VERTEX_PER_LINE];
    logic [CACHELINE_BITS-1:0] deg_line, idx_line, junk_line;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_fld(input logic [31:0] w);
`ifdef CU_VERTEX_ENDIAN_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_job(input bit ramp);
        for (int i = 0; i < VERTEX_PER_LINE; i++) begin
            dw[i] = ramp ? {8'(i + 1), 24'h0} : $urandom();
            iw[i] = $urandom();
            deg_line[i*VERTEX_BITS +: VERTEX_BITS] = dw[i];
            idx_line[i*VERTEX_BITS +: VERTEX_BITS] = iw[i];
        end
    endtask

    task automatic push_job(input int cnt, input logic [31:0] base);
        VertexInterface e;
        for (int k = 0; k < cnt; k++) begin
            e.valid              = 1'b1;
            e.id                 = base + 32'(k);
            e.inverse_out_degree = exp_fld(dw[k]);
            e.inverse_edges_idx  = exp_fld(iw[k]);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_line(input array_struct_type t, input logic [CACHELINE_BITS-1:0] d,
                             input logic [5:0] c, input logic [31:0] b);
        int guard;
        guard = 0;
        bus.resp_in_valid   = 1'b1;
        bus.resp_in_type    = t;
        bus.resp_in_data    = d;
        bus.resp_in_count   = c;
        bus.resp_in_base_id = b;
        #1;
        while (!bus.resp_in_ready && guard < 64) begin
            tick();
            #1;
            guard++;
        end
        check("resp_in_ready", 128'(bus.resp_in_ready), 128'(1'b1));
        tick();
        bus.resp_in_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [31:0] target);
        int guard;
        guard = 0;
        while (vertex_done_count != target && guard < 200) begin
            tick();
            guard++;
        end
        check("vertex_done_count", 128'(vertex_done_count), 128'(target));
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic flush();
        enabled_in = 1'b0;
        tick();
        enabled_in = 1'b1;
    endtask

    // Output monitor: every handshake pops the scoreboard; a stalled vertex
    // must reappear unchanged on the next cycle.
    always @(negedge clock) begin
        if (stall_pend) begin
            check("stall_valid_held", 128'(bus.vertex_out.valid), 128'(1'b1));
            check("stall_payload_held", 128'(bus.vertex_out), 128'(stall_val));
        end
        stall_pend <= 1'b0;
        if (rstn && enabled_in && bus.vertex_out.valid) begin
            if (bus.vertex_out_ready) begin
                check("scoreboard_has_entry", 128'(exp_q.size() > 0), 128'(1'b1));
                if (exp_q.size() > 0) begin
                    check("vertex_payload", 128'(bus.vertex_out), 128'(exp_q.pop_front()));
                end
            end else begin
                stall_pend <= 1'b1;
                stall_val  <= bus.vertex_out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               nvalid;
        logic [3:0]       pat;
        array_struct_type bad_t;
        logic [5:0]       bad_c;

        rstn                 = 1'b0;
        enabled_in           = 1'b1;
        bus.resp_in_valid    = 1'b0;
        bus.resp_in_type     = INV_OUT_DEGREE;
        bus.resp_in_data     = '0;
        bus.resp_in_count    = '0;
        bus.resp_in_base_id  = '0;
        bus.vertex_out_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        check("reset_ready", 128'(bus.resp_in_ready), 128'(1'b0));
        check("reset_vertex_out", 128'(bus.vertex_out), 128'(0));
        check("reset_done_count", 128'(vertex_done_count), 128'(0));
        check("reset_error", 128'(error_out), 128'(1'b0));
        rstn = 1'b1;
        #1;
        check("ready_after_reset", 128'(bus.resp_in_ready), 128'(1'b1));

        // Degree first, count 3, base 100, ramp degree words
        fill_job(1'b1);
        push_job(3, 32'd100);
        send_line(INV_OUT_DEGREE, deg_line, 6'd3, 32'd100);
        send_line(INV_EDGES_IDX, idx_line, 6'd3, 32'd100);
        wait_done(32'd3);
        check("job1_error", 128'(error_out), 128'(1'b0));

        // Idx first, full line of 32, continuous ready
        fill_job(1'b0);
        push_job(32, 32'h0000_1000);
        send_line(INV_EDGES_IDX, idx_line, 6'd32, 32'h0000_1000);
        send_line(INV_OUT_DEGREE, deg_line, 6'd32, 32'h0000_1000);
        check("latency_edge_n", 128'(bus.vertex_out.valid), 128'(1'b0));
        tick();
        check("latency_edge_n1", 128'(bus.vertex_out.valid), 128'(1'b1));
        nvalid = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus.vertex_out.valid) nvalid++;
            tick();
        end
        check("valid_run_length", 128'(nvalid), 128'(32));
        check("valid_after_run", 128'(bus.vertex_out.valid), 128'(1'b0));
        check("ready_in_done", 128'(bus.resp_in_ready), 128'(1'b0));
        tick();
        check("ready_after_done", 128'(bus.resp_in_ready), 128'(1'b1));
        check("done_count_job2", 128'(vertex_done_count), 128'(32'd35));

        // Backpressure 1,0,0,1
        fill_job(1'b0);
        push_job(4, 32'd7);
        send_line(INV_OUT_DEGREE, deg_line, 6'd4, 32'd7);
        send_line(INV_EDGES_IDX, idx_line, 6'd4, 32'd7);
        tick();
        pat = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            bus.vertex_out_ready = pat[i];
            tick();
        end
        bus.vertex_out_ready = 1'b1;
        wait_done(32'd39);
        check("backpressure_error", 128'(error_out), 128'(1'b0));

        // Duplicate degree line: second dropped, first kept
        fill_job(1'b0);
        junk_line = ~deg_line;
        push_job(5, 32'd200);
        send_line(INV_OUT_DEGREE, deg_line, 6'd5, 32'd200);
        send_line(INV_OUT_DEGREE, junk_line, 6'd5, 32'd200);
        check("dup_slot_error", 128'(error_out), 128'(1'b1));
        check("dup_slot_ready", 128'(bus.resp_in_ready), 128'(1'b1));
        send_line(INV_EDGES_IDX, idx_line, 6'd5, 32'd200);
        wait_done(32'd44);

        // Flush clears error and count
        flush();
        check("flush_error", 128'(error_out), 128'(1'b0));
        check("flush_done_count", 128'(vertex_done_count), 128'(0));
        #1;
        check("ready_after_flush", 128'(bus.resp_in_ready), 128'(1'b1));

        // Base mismatch 0 vs 32
        fill_job(1'b0);
        send_line(INV_OUT_DEGREE, deg_line, 6'd4, 32'd0);
        send_line(INV_EDGES_IDX, idx_line, 6'd4, 32'd32);
        check("mismatch_error", 128'(error_out), 128'(1'b1));
        check("mismatch_ready", 128'(bus.resp_in_ready), 128'(1'b1));
        repeat (3) begin
            check("mismatch_no_valid", 128'(bus.vertex_out.valid), 128'(1'b0));
            tick();
        end
        check("mismatch_no_emit", 128'(vertex_done_count), 128'(0));

        // Reset at k=5 of 10, then restart
        fill_job(1'b0);
        push_job(10, 32'd500);
        send_line(INV_OUT_DEGREE, deg_line, 6'd10, 32'd500);
        send_line(INV_EDGES_IDX, idx_line, 6'd10, 32'd500);
        repeat (6) tick();
        check("k5_id", 128'(bus.vertex_out.id), 128'(32'd505));
        check("k5_done_count", 128'(vertex_done_count), 128'(32'd5));
        rstn = 1'b0;
        tick();
        exp_q.delete();
        check("midshift_reset_vertex_out", 128'(bus.vertex_out), 128'(0));
        check("midshift_reset_done_count", 128'(vertex_done_count), 128'(0));
        check("midshift_reset_error", 128'(error_out), 128'(1'b0));
        check("midshift_reset_ready", 128'(bus.resp_in_ready), 128'(1'b0));
        rstn = 1'b1;
        #1;
        fill_job(1'b0);
        push_job(2, 32'd900);
        send_line(INV_OUT_DEGREE, deg_line, 6'd2, 32'd900);
        send_line(INV_EDGES_IDX, idx_line, 6'd2, 32'd900);
        wait_done(32'd2);

        // Malformed lines are dropped without touching a slot
        for (int c = 0; c < 3; c++) begin
            flush();
            bad_t = (c == 2) ? EDGES_ARRAY : INV_OUT_DEGREE;
            bad_c = (c == 0) ? 6'd0 : (c == 1) ? 6'd33 : 6'd1;
            fill_job(1'b0);
            send_line(bad_t, ~deg_line, bad_c, 32'd50);
            check("bad_line_error", 128'(error_out), 128'(1'b1));
            push_job(1, 32'd60);
            send_line(INV_OUT_DEGREE, deg_line, 6'd1, 32'd60);
            send_line(INV_EDGES_IDX, idx_line, 6'd1, 32'd60);
            wait_done(32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
